// File: rtl/tlk2711_pkg.sv
// Shared types and width helpers for the tlk2711 write-command arbiter.
package tlk2711_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    function automatic int cmd_width(input int addr_width, input int dlen_width);
        return addr_width + dlen_width;
    endfunction

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/tlk2711_id_fifo.sv
// Issue-order FIFO of requester IDs for commands accepted but not yet finished.
module tlk2711_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot, so a push into a full FIFO is legal in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tlk2711_wr_cmd_arb.sv
// Round-robin arbiter sharing the DMA write-command channel between NUM_REQ requesters,
// routing each write-complete pulse back to the requester that issued the command.
module tlk2711_wr_cmd_arb
    import tlk2711_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 48,
    parameter int DLEN_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             i_soft_rst,
    input  logic [NUM_REQ-1:0]                               i_req,
    input  logic [NUM_REQ*cmd_width(ADDR_WIDTH,DLEN_WIDTH)-1:0] i_cmd_data,
    output logic [NUM_REQ-1:0]                               o_ack,
    output logic [NUM_REQ-1:0]                               o_finish,
    output logic                                             o_cmd_req,
    output logic [cmd_width(ADDR_WIDTH,DLEN_WIDTH)-1:0]      o_cmd_data,
    input  logic                                             i_cmd_ack,
    input  logic                                             i_finish,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]             o_outstanding,
    output logic [id_width(NUM_REQ)-1:0]                     o_grant_id,
    output logic                                             o_busy,
    output logic                                             o_err_underflow
);
    localparam int CW = cmd_width(ADDR_WIDTH, DLEN_WIDTH);
    localparam int IW = id_width(NUM_REQ);

    arb_state_t    state;
    arb_state_t    state_next;
    logic          clr;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner;
    logic [IW-1:0] idx;
    logic          winner_vld;
    logic          grant;
    logic          push;
    logic          fifo_empty;
    logic          fifo_full;
    logic [IW-1:0] fifo_head;

    assign clr = rst || i_soft_rst;

    // Search starts one past the last grant and wraps, giving round-robin fairness.
    always_comb begin
        winner     = '0;
        winner_vld = 1'b0;
        idx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!winner_vld && i_req[idx]) begin
                winner     = idx;
                winner_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (winner_vld && !fifo_full) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (i_cmd_ack) begin
                    push       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            last_grant      <= IW'(NUM_REQ - 1);
            o_grant_id      <= '0;
            o_cmd_data      <= '0;
            o_cmd_req       <= 1'b0;
            o_ack           <= '0;
            o_finish        <= '0;
            o_err_underflow <= 1'b0;
        end else begin
            o_cmd_req <= (state_next == ISSUE);
            o_ack     <= push ? (NUM_REQ'(1) << o_grant_id) : '0;
            o_finish  <= (i_finish && !fifo_empty) ? (NUM_REQ'(1) << fifo_head) : '0;
            if (i_finish && fifo_empty) o_err_underflow <= 1'b1;
            if (grant) begin
                last_grant <= winner;
                o_grant_id <= winner;
                o_cmd_data <= CW'(i_cmd_data >> (int'(winner) * CW));
            end
        end
    end

    assign o_busy = (state != IDLE) || (o_outstanding != '0);

    tlk2711_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IW)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (clr),
        .push      (push),
        .push_data (o_grant_id),
        .pop       (i_finish),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (o_outstanding)
    );

endmodule
